// File: rtl/ss_pkg.sv
// Shared types and constants for the mapper save-state sequencer.
package ss_pkg;

  localparam int SS_ADDR_W   = 8;
  localparam int SS_DAT_W    = 8;
  localparam int SS_IDX_ADDR = 127;
  localparam int SETTLE_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SV_SET,
    SV_OUT,
    LD_GET,
    LD_WR,
    FIN
  } state_e;

  typedef enum logic {
    SAVE,
    LOAD
  } mode_e;

endpackage

// File: rtl/ss_settle_cnt.sv
// Loadable down-counter that times the mapper read-data settle window.
module ss_settle_cnt
  import ss_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = SETTLE_W'(SETTLE);
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop updates together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ss_seq.sv
// Save-state sequencer: walks mapper save-state addresses, streaming bytes out on
// save and writing a byte stream back on load, paced by the mapper m2 strobe.
module ss_seq
  import ss_pkg::*;
#(
  parameter int unsigned REG_COUNT = SS_IDX_ADDR + 1,
  parameter int unsigned SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m2_fall,
  input  logic                 save_req,
  input  logic                 load_req,
  output logic                 busy,
  output logic                 done,
  output logic                 ss_act,
  output logic                 ss_we,
  output logic [SS_ADDR_W-1:0] ss_addr,
  output logic [SS_DAT_W-1:0]  ss_wdat,
  input  logic [SS_DAT_W-1:0]  ss_rdat,
  output logic [SS_DAT_W-1:0]  sv_dat,
  output logic                 sv_vld,
  input  logic                 sv_rdy,
  input  logic [SS_DAT_W-1:0]  ld_dat,
  input  logic                 ld_vld,
  output logic                 ld_rdy
);

  localparam logic [SS_ADDR_W-1:0] LAST_ADDR = SS_ADDR_W'(REG_COUNT - 1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [SS_ADDR_W-1:0] addr_q, addr_d;
  logic [SS_DAT_W-1:0]  sv_dat_q, sv_dat_d;
  logic [SS_DAT_W-1:0]  wdat_q, wdat_d;
  logic                 done_q, done_d;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;

  // The counter is reloaded on every SV_SET entry, which is also when ss_addr moves.
  ss_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  assign cnt_dec = (state_q == SV_SET);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= SAVE;
      addr_q   <= '0;
      sv_dat_q <= '0;
      wdat_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      sv_dat_q <= sv_dat_d;
      wdat_q   <= wdat_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    sv_dat_d = sv_dat_q;
    wdat_d   = wdat_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Save has priority when both requests land together.
        if (save_req) begin
          mode_d  = SAVE;
          addr_d  = '0;
          state_d = ARM;
        end else if (load_req) begin
          mode_d  = LOAD;
          addr_d  = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (m2_fall) begin
          if (mode_q == SAVE) begin
            cnt_load = 1'b1;
            state_d  = SV_SET;
          end else begin
            state_d = LD_GET;
          end
        end
      end
      SV_SET: begin
        if (cnt_zero) begin
          sv_dat_d = ss_rdat;
          state_d  = SV_OUT;
        end
      end
      SV_OUT: begin
        if (sv_rdy) begin
          if (addr_q == LAST_ADDR) begin
            state_d = FIN;
          end else begin
            addr_d   = addr_q + SS_ADDR_W'(1);
            cnt_load = 1'b1;
            state_d  = SV_SET;
          end
        end
      end
      LD_GET: begin
        if (ld_vld) begin
          wdat_d  = ld_dat;
          state_d = LD_WR;
        end
      end
      LD_WR: begin
        if (m2_fall) begin
          if (addr_q == LAST_ADDR) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + SS_ADDR_W'(1);
            state_d = LD_GET;
          end
        end
      end
      FIN: begin
        if (m2_fall) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    ss_act  = (state_q != IDLE);
    ss_we   = (state_q == LD_WR);
    sv_vld  = (state_q == SV_OUT);
    ld_rdy  = (state_q == LD_GET);
    done    = done_q;
    ss_addr = addr_q;
    ss_wdat = wdat_q;
    sv_dat  = sv_dat_q;
  end

endmodule

// File: tb/tb_ss_seq.sv
// Self-checking bench for ss_seq: a 4-address instance for save/load/reset
// scenarios and a 256-address instance for the full-range save.
module tb_ss_seq;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m2_fall = 1'b0;
  logic       sv_rdy = 1'b1;
  logic [7:0] ld_dat = 8'h00;
  logic       ld_vld = 1'b0;

  logic       save_req = 1'b0, load_req = 1'b0;
  logic       busy, done, ss_act, ss_we, sv_vld, ld_rdy;
  logic [7:0] ss_addr, ss_wdat, sv_dat;
  logic [7:0] ss_rdat = 8'h00, rd_p1 = 8'h00;

  logic       big_save_req = 1'b0, big_load_req = 1'b0;
  logic       big_busy, big_done, big_ss_act, big_ss_we, big_sv_vld, big_ld_rdy;
  logic [7:0] big_ss_addr, big_ss_wdat, big_sv_dat;
  logic [7:0] big_ss_rdat = 8'h00, big_rd_p1 = 8'h00;

  always #5 clk = ~clk;

  ss_seq #(.REG_COUNT(4), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst(rst), .m2_fall(m2_fall), .save_req(save_req), .load_req(load_req),
    .busy(busy), .done(done), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
    .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .sv_dat(sv_dat), .sv_vld(sv_vld),
    .sv_rdy(sv_rdy), .ld_dat(ld_dat), .ld_vld(ld_vld), .ld_rdy(ld_rdy)
  );

  ss_seq #(.REG_COUNT(256), .SETTLE(SETTLE)) u_big (
    .clk(clk), .rst(rst), .m2_fall(m2_fall), .save_req(big_save_req), .load_req(big_load_req),
    .busy(big_busy), .done(big_done), .ss_act(big_ss_act), .ss_we(big_ss_we),
    .ss_addr(big_ss_addr), .ss_wdat(big_ss_wdat), .ss_rdat(big_ss_rdat), .sv_dat(big_sv_dat),
    .sv_vld(big_sv_vld), .sv_rdy(sv_rdy), .ld_dat(ld_dat), .ld_vld(ld_vld), .ld_rdy(big_ld_rdy)
  );

  // Mapper model: register contents are addr^A5, read data valid two clocks after the address.
  always @(posedge clk) begin
    rd_p1       <= ss_addr ^ 8'hA5;
    ss_rdat     <= rd_p1;
    big_rd_p1   <= big_ss_addr ^ 8'hA5;
    big_ss_rdat <= big_rd_p1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Background pacing: m2_fall every 5 clk, sv_rdy either held high or toggling every 3 clk.
  bit rdy_toggle = 1'b0;
  initial begin
    int m2_cnt = 0;
    int tog_cnt = 0;
    forever begin
      @(negedge clk);
      m2_cnt  = (m2_cnt + 1) % 5;
      m2_fall = (m2_cnt == 0);
      if (rdy_toggle) begin
        tog_cnt++;
        if (tog_cnt == 3) begin
          sv_rdy  = ~sv_rdy;
          tog_cnt = 0;
        end
      end else begin
        sv_rdy  = 1'b1;
        tog_cnt = 0;
      end
    end
  end

  // Scoreboard state
  logic [7:0]  sv_exp[$];
  logic [7:0]  sv_got[$];
  int          hs_cyc[$];
  logic [7:0]  ld_exp[$];
  logic [15:0] wr_log[$];
  int          ld_next_addr = 0;
  int          done_count = 0;
  int          ld_rdy_seen = 0;
  int          stalls = 0;
  int          cyc = 0;
  int          big_cnt = 0;
  int          big_done_count = 0;
  logic [7:0]  big_last_addr = 8'h00;

  logic       prev_rst = 1'b1, prev_vld = 1'b0, prev_rdy = 1'b0, prev_we = 1'b0;
  logic       prev_m2 = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  // Compare process: samples just after the falling edge, away from the active edge.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    check("vld_rdy_exclusive", {31'd0, sv_vld & ld_rdy}, 0);
    check("act_tracks_busy", {31'd0, ss_act}, {31'd0, busy});
    if (ss_we) check("we_context", {29'd0, ss_act, ld_rdy, sv_vld}, 32'b100);
    if (ld_rdy) ld_rdy_seen++;

    if (sv_vld && sv_rdy && !rst) begin
      check("sv_byte_expected", {31'd0, sv_exp.size() != 0}, 1);
      if (sv_exp.size() != 0) check("sv_dat", {24'd0, sv_dat}, {24'd0, sv_exp.pop_front()});
      sv_got.push_back(sv_dat);
      hs_cyc.push_back(cyc);
    end
    if (prev_vld && !prev_rdy && !prev_rst) begin
      stalls++;
      check("sv_hold_vld", {31'd0, sv_vld}, 1);
      check("sv_hold_dat", {24'd0, sv_dat}, {24'd0, prev_dat});
    end

    if (ss_we && m2_fall && !rst) begin
      check("wr_expected", {31'd0, ld_exp.size() != 0}, 1);
      if (ld_exp.size() != 0) begin
        check("wr_addr", {24'd0, ss_addr}, ld_next_addr);
        check("wr_dat", {24'd0, ss_wdat}, {24'd0, ld_exp.pop_front()});
      end
      ld_next_addr++;
      wr_log.push_back({ss_addr, ss_wdat});
    end
    if (prev_we && !ss_we && !prev_rst) check("we_drop_on_m2", {31'd0, prev_m2}, 1);

    if (done) begin
      done_count++;
      check("done_busy_low", {31'd0, busy}, 0);
      check("done_act_low", {31'd0, ss_act}, 0);
      check("done_prev_busy", {31'd0, prev_busy}, 1);
    end

    check("big_vld_rdy_exclusive", {31'd0, big_sv_vld & big_ld_rdy}, 0);
    check("big_act_tracks_busy", {31'd0, big_ss_act}, {31'd0, big_busy});
    check("big_no_write", {23'd0, big_ss_we, big_ss_wdat}, 0);
    if (big_sv_vld && sv_rdy && !rst) begin
      check("big_sv_dat", {24'd0, big_sv_dat}, {24'd0, 8'(big_cnt) ^ 8'hA5});
      check("big_addr_no_wrap", {24'd0, big_ss_addr}, big_cnt);
      big_cnt++;
    end
    if (big_done) begin
      big_done_count++;
      big_last_addr = big_ss_addr;
    end

    prev_rst  = rst;
    prev_vld  = sv_vld;
    prev_rdy  = sv_rdy;
    prev_dat  = sv_dat;
    prev_we   = ss_we;
    prev_m2   = m2_fall;
    prev_busy = busy;
  end

  task automatic pulse_req(input logic s, input logic l);
    @(negedge clk);
    save_req = s;
    load_req = l;
    @(negedge clk);
    save_req = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start = done_count;
    int n = 0;
    while (done_count == start && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(name, done_count - start, 1);
  endtask

  task automatic feed_byte(input logic [7:0] b);
    int n = 0;
    ld_dat = b;
    ld_vld = 1'b1;
    while (!ld_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ld_accept_in_time", {31'd0, n < 200}, 1);
    @(negedge clk);
    ld_vld = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_ss_act"}, {31'd0, ss_act}, 0);
    check({tag, "_ss_we"}, {31'd0, ss_we}, 0);
    check({tag, "_ss_addr"}, {24'd0, ss_addr}, 0);
    check({tag, "_ss_wdat"}, {24'd0, ss_wdat}, 0);
    check({tag, "_sv_dat"}, {24'd0, sv_dat}, 0);
    check({tag, "_sv_vld"}, {31'd0, sv_vld}, 0);
    check({tag, "_ld_rdy"}, {31'd0, ld_rdy}, 0);
  endtask

  task automatic expect_save_stream();
    sv_exp.delete();
    sv_got.delete();
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) sv_exp.push_back(8'(i) ^ 8'hA5);
  endtask

  initial begin
    logic [7:0]  lit_save[4];
    logic [15:0] lit_load[4];
    logic [7:0]  first_stream[4];
    int          wr_before;
    int          done_before;
    lit_save = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
    lit_load = '{16'h0011, 16'h0122, 16'h0233, 16'h0344};

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check_all_zero("reset");
    check("reset_big_busy", {31'd0, big_busy}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Save with sv_rdy held high
    expect_save_stream();
    pulse_req(1'b1, 1'b0);
    wait_done("save1_done", 300);
    check("save1_handshakes", sv_got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      first_stream[i] = (i < sv_got.size()) ? sv_got[i] : 8'hxx;
      check("save1_literal", {24'd0, first_stream[i]}, {24'd0, lit_save[i]});
    end
    for (int i = 1; i < 4; i++)
      if (i < hs_cyc.size()) check("save1_byte_period", hs_cyc[i] - hs_cyc[i-1], SETTLE + 2);
    check("save1_done_once", done_count, 1);
    check("save1_no_ld_rdy", ld_rdy_seen, 0);

    // Save with sv_rdy toggling every 3 clk
    expect_save_stream();
    stalls = 0;
    rdy_toggle = 1'b1;
    pulse_req(1'b1, 1'b0);
    wait_done("save2_done", 400);
    rdy_toggle = 1'b0;
    check("save2_handshakes", sv_got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < sv_got.size()) check("save2_same_stream", {24'd0, sv_got[i]}, {24'd0, first_stream[i]});
    check("save2_saw_stall", {31'd0, stalls > 0}, 1);

    // Load 11, 22, 33, 44
    wr_log.delete();
    ld_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    ld_next_addr = 0;
    pulse_req(1'b0, 1'b1);
    feed_byte(8'h11);
    feed_byte(8'h22);
    feed_byte(8'h33);
    feed_byte(8'h44);
    wait_done("load_done", 300);
    check("load_write_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wr_log.size()) check("load_literal", {16'd0, wr_log[i]}, {16'd0, lit_load[i]});

    // Simultaneous requests: save wins; a load_req while busy is ignored
    expect_save_stream();
    wr_before = wr_log.size();
    ld_rdy_seen = 0;
    pulse_req(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    pulse_req(1'b0, 1'b1);
    wait_done("both_done", 300);
    check("both_save_bytes", sv_got.size(), 4);
    check("both_no_ld_rdy", ld_rdy_seen, 0);
    check("both_no_writes", wr_log.size(), wr_before);
    repeat (10) @(negedge clk);
    #2;
    check("both_idle_after", {31'd0, busy}, 0);

    // Reset mid-load after 2 bytes
    wr_log.delete();
    ld_exp = '{8'hC1, 8'hC2};
    ld_next_addr = 0;
    done_before = done_count;
    pulse_req(1'b0, 1'b1);
    feed_byte(8'hC1);
    feed_byte(8'hC2);
    for (int n = 0; n < 50 && wr_log.size() < 2; n++) begin
      @(negedge clk);
      #2;
    end
    check("rst_two_writes", wr_log.size(), 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    check("midrst_no_done", done_count, done_before);

    // Fresh load restarts at address 0
    wr_log.delete();
    ld_exp = '{8'h55, 8'h66, 8'h77, 8'h88};
    ld_next_addr = 0;
    pulse_req(1'b0, 1'b1);
    feed_byte(8'h55);
    feed_byte(8'h66);
    feed_byte(8'h77);
    feed_byte(8'h88);
    wait_done("reload_done", 300);
    if (wr_log.size() > 0) check("reload_first", {16'd0, wr_log[0]}, 32'h0055);
    check("reload_count", wr_log.size(), 4);

    // Full 256-address save
    big_cnt = 0;
    @(negedge clk);
    big_save_req = 1'b1;
    @(negedge clk);
    big_save_req = 1'b0;
    for (int n = 0; n < 5000 && big_done_count == 0; n++) begin
      @(negedge clk);
      #2;
    end
    check("big_done_once", big_done_count, 1);
    check("big_bytes", big_cnt, 256);
    check("big_last_addr", {24'd0, big_last_addr}, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
